// File: rtl/mio_counter_pkg.sv
// Shared constants for the mio_counter timer block: channel modes, register map
// and CTRL field layout.
package mio_counter_pkg;

    localparam int NUM_CH = 3;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_RATE    = 2'd1,
        MODE_SQUARE  = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    localparam logic [1:0] ADDR_CH0  = 2'd0;
    localparam logic [1:0] ADDR_CH1  = 2'd1;
    localparam logic [1:0] ADDR_CH2  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_CH_STRIDE = 4;
    localparam int CTRL_MODE_LSB  = 0;
    localparam int CTRL_EN_BIT    = 2;

    // Bit 3 of every channel nibble is unimplemented and always reads 0.
    localparam logic [11:0] CTRL_MASK = 12'h777;

    function automatic logic [2:0] ctrl_field(input logic [11:0] ctrl, input int ch);
        return ctrl[ch * CTRL_CH_STRIDE +: 3];
    endfunction

endpackage

// File: rtl/mio_counter_if.sv
// CPU-side register bus of the counter window: decoded write strobe, register
// select, write data and combinational readback.
interface mio_counter_if;
    logic        counter_we;
    logic [1:0]  counter_addr;
    logic [31:0] Peripheral_in;
    logic [31:0] counter_out;

    modport master (output counter_we, output counter_addr, output Peripheral_in,
                    input counter_out);
    modport slave  (input counter_we, input counter_addr, input Peripheral_in,
                    output counter_out);
endinterface

// File: rtl/mio_counter_chan.sv
// One 32-bit down-counter channel: count, reload value and registered output,
// advanced on prescaler ticks according to its mode.
module mio_counter_chan
    import mio_counter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic        i_en,
    input  mode_e       i_mode,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic        o_out
);

    logic [31:0] r_count;
    logic [31:0] r_reload;
    logic        r_out;
    logic        w_adv;
    logic        w_last;

    // A count of zero never advances, so there is no wrap below zero.
    assign w_adv  = i_tick && i_en && (r_count != 32'd0);
    assign w_last = (r_count == 32'd1);

    // Channel state update: a write always wins over the tick in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= 32'd0;
            r_reload <= 32'd0;
            r_out    <= 1'b0;
        end else if (i_we) begin
            r_reload <= i_wdata;
            r_count  <= i_wdata;
            r_out    <= (i_mode == MODE_SQUARE);
        end else if (w_adv) begin
            case (i_mode)
                MODE_ONESHOT: begin
                    r_count <= r_count - 32'd1;
                    if (w_last) begin
                        r_out <= 1'b1;
                    end
                end
                MODE_RATE: begin
                    if (w_last) begin
                        r_count <= r_reload;
                        r_out   <= 1'b1;
                    end else begin
                        r_count <= r_count - 32'd1;
                        r_out   <= 1'b0;
                    end
                end
                MODE_SQUARE: begin
                    if (w_last) begin
                        r_count <= r_reload;
                        r_out   <= ~r_out;
                    end else begin
                        r_count <= r_count - 32'd1;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end else if (i_mode == MODE_RATE) begin
            // Rate pulse lasts a single clock even when the next tick is far away.
            r_out <= 1'b0;
        end else begin
            r_out <= r_out;
        end
    end

    assign o_count = r_count;
    assign o_out   = r_out;

endmodule

// File: rtl/mio_counter.sv
// Counter/timer window responder: prescaler, CTRL register, write decode,
// readback mux and three down-counter channels.
module mio_counter
    import mio_counter_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int PS_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    mio_counter_if.slave  bus,
    output logic          counter0_out,
    output logic          counter1_out,
    output logic          counter2_out
);

    logic [PS_W-1:0]   r_ps;
    logic [11:0]       r_ctrl;
    logic              w_tick;
    logic [NUM_CH-1:0] w_we;
    logic [NUM_CH-1:0] w_out;
    logic [31:0]       w_count [NUM_CH];
    logic [31:0]       w_rdata;

    assign w_tick = (r_ps == PS_W'(PRESCALE - 1));

    // Free-running prescaler, wraps in the tick cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ps <= '0;
        end else if (w_tick) begin
            r_ps <= '0;
        end else begin
            r_ps <= r_ps + 1'b1;
        end
    end

    // CTRL register; channels see the old value during the write cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= 12'd0;
        end else if (bus.counter_we && (bus.counter_addr == ADDR_CTRL)) begin
            r_ctrl <= bus.Peripheral_in[11:0] & CTRL_MASK;
        end else begin
            r_ctrl <= r_ctrl;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [2:0] w_field;
        assign w_field = ctrl_field(r_ctrl, g);
        assign w_we[g] = bus.counter_we && (bus.counter_addr == 2'(g));

        mio_counter_chan u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_tick  (w_tick),
            .i_en    (w_field[CTRL_EN_BIT]),
            .i_mode  (mode_e'(w_field[CTRL_MODE_LSB +: 2])),
            .i_we    (w_we[g]),
            .i_wdata (bus.Peripheral_in),
            .o_count (w_count[g]),
            .o_out   (w_out[g])
        );
    end

    // Zero-latency readback of the selected register.
    always_comb begin
        w_rdata = 32'd0;
        case (bus.counter_addr)
            ADDR_CH0:  w_rdata = w_count[0];
            ADDR_CH1:  w_rdata = w_count[1];
            ADDR_CH2:  w_rdata = w_count[2];
            ADDR_CTRL: w_rdata = {20'd0, r_ctrl};
            default:   w_rdata = 32'd0;
        endcase
    end

    assign bus.counter_out = w_rdata;
    assign counter0_out    = w_out[0];
    assign counter1_out    = w_out[1];
    assign counter2_out    = w_out[2];

endmodule

// File: tb/tb_mio_counter.sv
// Self-checking bench for mio_counter: a vector table on a PRESCALE=1 instance
// plus hand sequences for collisions, hold mode, reset and a PRESCALE=4 instance.
module tb_mio_counter;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] rd;
        logic [2:0]  outs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic a_o0, a_o1, a_o2;
    logic b_o0, b_o1, b_o2;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mio_counter_if bus_a ();
    mio_counter_if bus_b ();

    mio_counter #(.PRESCALE(1), .PS_W(16)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a),
        .counter0_out(a_o0), .counter1_out(a_o1), .counter2_out(a_o2)
    );

    mio_counter #(.PRESCALE(4), .PS_W(16)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b),
        .counter0_out(b_o0), .counter1_out(b_o1), .counter2_out(b_o2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] addr, input logic [31:0] data,
                       input logic [31:0] rd, input logic [2:0] outs);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.rd = rd; v.outs = outs;
        vecs.push_back(v);
    endtask

    task automatic step_a(input logic we, input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_a.counter_we = we;
        bus_a.counter_addr = addr;
        bus_a.Peripheral_in = data;
        @(posedge clk);
        #1;
        bus_a.counter_we = 1'b0;
    endtask

    task automatic step_b(input logic we, input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_b.counter_we = we;
        bus_b.counter_addr = addr;
        bus_b.Peripheral_in = data;
        @(posedge clk);
        #1;
        bus_b.counter_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_b1 [6];
        logic        exp_bo [6];
        logic [31:0] exp_b2 [7];

        bus_a.counter_we = 1'b1;
        bus_a.counter_addr = 2'd0;
        bus_a.Peripheral_in = 32'h1234;
        bus_b.counter_we = 1'b0;
        bus_b.counter_addr = 2'd0;
        bus_b.Peripheral_in = 32'd0;

        // Reset vectors, then one-shot, rate, CTRL masking, square wave.
        for (int i = 0; i < 4; i++) add(1'b0, 2'(i), 32'd0, 32'd0, 3'b000);
        add(1'b1, 2'd0, 32'd5,   32'd5,   3'b000);
        add(1'b1, 2'd3, 32'h004, 32'h004, 3'b000);
        add(1'b0, 2'd0, 32'd0, 32'd4, 3'b000);
        add(1'b0, 2'd0, 32'd0, 32'd3, 3'b000);
        add(1'b0, 2'd0, 32'd0, 32'd2, 3'b000);
        add(1'b0, 2'd0, 32'd0, 32'd1, 3'b000);
        add(1'b0, 2'd0, 32'd0, 32'd0, 3'b001);
        add(1'b0, 2'd0, 32'd0, 32'd0, 3'b001);
        add(1'b1, 2'd1, 32'd3,   32'd3,   3'b001);
        add(1'b1, 2'd3, 32'h050, 32'h050, 3'b001);
        add(1'b0, 2'd1, 32'd0, 32'd2, 3'b001);
        add(1'b0, 2'd1, 32'd0, 32'd1, 3'b001);
        add(1'b0, 2'd1, 32'd0, 32'd3, 3'b011);
        add(1'b0, 2'd1, 32'd0, 32'd2, 3'b001);
        add(1'b1, 2'd3, 32'hFFFF_F858, 32'h050, 3'b001);
        add(1'b0, 2'd1, 32'd0, 32'd3, 3'b011);
        add(1'b0, 2'd1, 32'd0, 32'd2, 3'b001);
        add(1'b1, 2'd3, 32'h600, 32'h600, 3'b001);
        add(1'b0, 2'd1, 32'd0, 32'd1, 3'b001);
        add(1'b1, 2'd2, 32'd4, 32'd4, 3'b101);
        add(1'b0, 2'd2, 32'd0, 32'd3, 3'b101);
        add(1'b0, 2'd2, 32'd0, 32'd2, 3'b101);
        add(1'b0, 2'd2, 32'd0, 32'd1, 3'b101);
        add(1'b0, 2'd2, 32'd0, 32'd4, 3'b001);
        add(1'b0, 2'd2, 32'd0, 32'd3, 3'b001);
        add(1'b0, 2'd2, 32'd0, 32'd2, 3'b001);
        add(1'b0, 2'd2, 32'd0, 32'd1, 3'b001);
        add(1'b0, 2'd2, 32'd0, 32'd4, 3'b101);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_we_ignored", bus_a.counter_out, 32'd0);
        chk("reset_outs", {29'd0, a_o2, a_o1, a_o0}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        bus_a.counter_we = 1'b0;

        foreach (vecs[i]) begin
            step_a(vecs[i].we, vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d_rd", i), bus_a.counter_out, vecs[i].rd);
            chk($sformatf("vec%0d_outs", i), {29'd0, a_o2, a_o1, a_o0}, {29'd0, vecs[i].outs});
        end

        // Collision: channel write wins while a neighbour keeps counting.
        step_a(1'b1, 2'd3, 32'h000);
        step_a(1'b1, 2'd0, 32'd7);
        step_a(1'b1, 2'd1, 32'd20);
        step_a(1'b1, 2'd3, 32'h044);
        chk("ctrl_044", bus_a.counter_out, 32'h044);
        step_a(1'b0, 2'd0, 32'd0);
        chk("pre_coll_ch0", bus_a.counter_out, 32'd6);
        step_a(1'b0, 2'd1, 32'd0);
        chk("pre_coll_ch1", bus_a.counter_out, 32'd18);
        step_a(1'b1, 2'd0, 32'd10);
        chk("coll_ch0", bus_a.counter_out, 32'd10);
        bus_a.counter_addr = 2'd1;
        #1;
        chk("coll_ch1", bus_a.counter_out, 32'd17);
        step_a(1'b0, 2'd0, 32'd0);
        chk("post_coll_ch0", bus_a.counter_out, 32'd9);

        // Hold mode on ch0 while ch1 keeps counting.
        step_a(1'b1, 2'd3, 32'h047);
        step_a(1'b0, 2'd0, 32'd0);
        chk("hold_ch0", bus_a.counter_out, 32'd8);
        step_a(1'b0, 2'd1, 32'd0);
        chk("hold_ch1", bus_a.counter_out, 32'd13);
        step_a(1'b0, 2'd0, 32'd0);
        chk("hold_ch0_again", bus_a.counter_out, 32'd8);

        // Reset mid-count, with a write that must be ignored.
        @(negedge clk);
        rst_a = 1'b1;
        bus_a.counter_we = 1'b1;
        bus_a.counter_addr = 2'd1;
        bus_a.Peripheral_in = 32'd99;
        @(posedge clk);
        #1;
        chk("midrst_ch1", bus_a.counter_out, 32'd0);
        bus_a.counter_we = 1'b0;
        bus_a.counter_addr = 2'd3;
        #1;
        chk("midrst_ctrl", bus_a.counter_out, 32'd0);
        chk("midrst_outs", {29'd0, a_o2, a_o1, a_o0}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;

        // Prescale 4: one-shot of 2 lands on the second tick.
        exp_b1 = '{32'd2, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0};
        exp_bo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        rst_b = 1'b0;
        bus_b.counter_we = 1'b1;
        bus_b.counter_addr = 2'd0;
        bus_b.Peripheral_in = 32'd2;
        @(posedge clk);
        #1;
        bus_b.counter_we = 1'b0;
        chk("ps_wr_ch0", bus_b.counter_out, 32'd2);
        step_b(1'b1, 2'd3, 32'h004);
        chk("ps_ctrl", bus_b.counter_out, 32'h004);
        for (int i = 0; i < 6; i++) begin
            step_b(1'b0, 2'd0, 32'd0);
            chk($sformatf("ps_cnt%0d", i), bus_b.counter_out, exp_b1[i]);
            chk($sformatf("ps_out%0d", i), {31'd0, b_o0}, {31'd0, exp_bo[i]});
        end

        // Prescale 4: disable mid-count freezes, re-enable resumes.
        exp_b2 = '{32'd8, 32'd8, 32'd7, 32'd7, 32'd7, 32'd7, 32'd6};
        step_b(1'b1, 2'd0, 32'd8);
        chk("ps_rewr", bus_b.counter_out, 32'd8);
        chk("ps_rewr_out", {31'd0, b_o0}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            step_b(1'b0, 2'd0, 32'd0);
            chk($sformatf("ps_run%0d", i), bus_b.counter_out, exp_b2[i]);
        end
        step_b(1'b1, 2'd3, 32'h000);
        for (int i = 0; i < 7; i++) begin
            step_b(1'b0, 2'd0, 32'd0);
            chk($sformatf("ps_frozen%0d", i), bus_b.counter_out, 32'd6);
        end
        step_b(1'b1, 2'd3, 32'h004);
        step_b(1'b0, 2'd0, 32'd0);
        chk("ps_resume0", bus_b.counter_out, 32'd6);
        step_b(1'b0, 2'd0, 32'd0);
        chk("ps_resume1", bus_b.counter_out, 32'd6);
        step_b(1'b0, 2'd0, 32'd0);
        chk("ps_resume2", bus_b.counter_out, 32'd5);
        chk("ps_other_outs", {30'd0, b_o2, b_o1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
